ps2_event_fifo: RTL and testbench
=================================

# ps2_event_fifo

Parametrised PS/2 keyboard receiver that sits between the raw ps2clk/ps2data pins and the display logic in the clk25 domain. It filters the PS/2 clock, deserialises 11-bit frames and checks start, stop and odd parity. It decodes the E0 (extended) and F0 (break) prefixes into tagged key events, and buffers those events in a ready/valid FIFO. Unlike a single-register, release-only receiver, it reports make and break events, extended keys, framing/parity/timeout errors and FIFO overflow, and no keystroke is lost while the consumer is busy.

## Interface
- FILT, 8: ps2clk filter length (even, ≥4). The last FILT synchronised samples are kept.
- TIMEOUT, 2500: clk cycles without a falling edge, mid-frame, before the frame is aborted.
- DEPTH, 8: FIFO entries; a power of two, ≥2. AW = log2(DEPTH) is derived internally.

- clk  in  1  receiver and FIFO clock
- reset  in  1  asynchronous, active-high
- ps2clk  in  1  raw PS/2 clock, asynchronous
- ps2data  in  1  raw PS/2 data, asynchronous, two-flop synchronised
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head this cycle
- ev_code  out  8  scancode at the FIFO head
- ev_ext  out  1  head event was preceded by E0
- ev_brk  out  1  head event was preceded by F0 (key release)
- err_parity  out  1  one-cycle pulse on a parity failure
- err_frame  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- level  out  AW+1  current FIFO occupancy, 0..DEPTH

## Operation
- Edge detect: sample shift register of FILT bits. fall_edge is true when the oldest FILT/2 bits are all 1 and the newest FILT/2 bits are all 0.
- Frame receiver, states IDLE and SHIFT, with bit counter bcnt 0..10:
  - IDLE: on fall_edge, capture the start bit, set bcnt=1 and enter SHIFT.
  - SHIFT: on each fall_edge, shift synchronised ps2data in LSB-first and increment bcnt.
  - At bcnt=10 (the stop bit), check the frame, then return to IDLE.
- Frame check, in priority order:
  - start≠0 or stop≠1 → err_frame.
  - else ^{data[7:0],parity}≠1 → err_parity.
  - else deliver the byte to the decoder.
  - Any error discards the byte and clears both prefix flags.
- Timeout: a counter clears on every fall_edge and on IDLE. If it reaches TIMEOUT while in SHIFT: go to IDLE, pulse err_frame, clear the prefix flags.
- Decoder:
  - 0xE0 → ext_pend=1.
  - 0xF0 → brk_pend=1.
  - Any other byte → push {ext_pend, brk_pend, byte} and clear both flags.
  - Prefixes accumulate in any order; E0 F0 74 yields ext=1, brk=1.
- FIFO: show-ahead, so the head is always driven on ev_code/ev_ext/ev_brk. ev_valid = (level≠0). Pop when ev_valid&ev_ready.
- Full + push without pop: drop the new event, set overflow, leave the FIFO unchanged.
- Full + push with pop in the same cycle: both happen, level stays DEPTH, no overflow.
- Empty + push: the event appears next cycle; a pop cannot be requested the same cycle.
- Reset values, applied asynchronously: all outputs 0, FIFO empty, state IDLE, prefix flags 0, filter all 0, overflow 0. Reset mid-frame discards the partial frame; no error pulse.

## Timing
- Define cycle E as the clk in which fall_edge is true for the stop bit.
- E+1: the decoder registers the byte and the FIFO write occurs; err_parity/err_frame pulse in this cycle for exactly 1 clk.
- E+2: ev_valid=1 if the FIFO was empty; level is incremented.
- Pop: ev_valid/head and level update on the clk after ev_valid&ev_ready. Throughput is 1 event per clk.
- Edge detect latency: 2 sync flops + FILT/2 clks after the physical ps2clk fall.
- Timeout error pulse: TIMEOUT clks after the last fall_edge, ±1.

## Test plan
- Make 'A' (frame 0x1C, parity 0) with ev_ready=1 → one event: code=0x1C, ext=0, brk=0; ev_valid high exactly 1 clk at E+2; no errors.
- Stream E0 74, then E0 F0 74 → two events: {0x74, ext=1, brk=0} and {0x74, ext=1, brk=1}; E0/F0 are never pushed.
- Frame 0x1C sent with parity=1 → err_parity for 1 clk at E+1; level stays 0. A following valid 0x1C is then accepted with brk=0, showing F0/E0 pending state was cleared.
- DEPTH=4, ev_ready=0, send 5 make codes 0x16,0x1E,0x26,0x25,0x2E → level=4, overflow=1. Raise ev_ready → codes 0x16,0x1E,0x26,0x25 in order; 0x2E lost.
- Send 4 data bits then stop ps2clk → err_frame after TIMEOUT clks. A following complete 0x16 frame is received correctly.
- Assert reset mid-frame with FIFO level=2 → level=0, ev_valid=0, overflow=0, no error pulse. A subsequent 0x1C frame yields one correct event.

Source files
------------

// File: rtl/ps2_event_fifo.sv
// PS/2 keyboard receiver: filters ps2clk, deframes 11-bit frames, tags E0/F0 prefixes
// and queues {ext, brk, code} events in a show-ahead ready/valid FIFO.

// Generic show-ahead FIFO with occupancy count and sticky drop flag.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: head held until rd_rdy; a write into a full FIFO is accepted only with a same-cycle pop.
module ps2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [AW:0]      level,
    output logic             ovf
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full   = (level == (AW+1)'(DEPTH));
    assign rd_vld = (level != '0);
    assign pop    = rd_vld & rd_rdy;
    assign wr_en  = wr_vld & (~full | pop);
    assign rd_dat = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_dat;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (wr_en && !pop)      level <= level + 1'b1;
            else if (!wr_en && pop) level <= level - 1'b1;
            if (wr_vld && full && !pop) ovf <= 1'b1;
        end
    end
endmodule

// PS/2 receiver top: edge filter, frame FSM, prefix decoder, event FIFO.
// Latency: error pulse at E+1, event at FIFO head at E+2 (E = stop-bit fall_edge cycle).
// Backpressure: events wait in the FIFO for ev_ready; a push into a full FIFO is dropped and flagged.
module ps2_event_fifo #(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 2500,
    parameter int DEPTH   = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2clk,
    input  logic        ps2data,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_code,
    output logic        ev_ext,
    output logic        ev_brk,
    output logic        err_parity,
    output logic        err_frame,
    output logic        overflow,
    output logic [AW:0] level
);
    localparam int HALF = FILT / 2;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef enum logic {IDLE, SHIFT} st_t;

    logic            clk_s1, clk_s2;
    logic            dat_s1, dat_s2;
    logic [FILT-1:0] filt;
    logic            fall_edge;

    st_t             st;
    logic [3:0]      bcnt;
    logic [8:0]      sh;
    logic            start_bit;
    logic [TW-1:0]   to_cnt;
    logic            rx_vld;
    logic [7:0]      rx_byte;

    logic            ext_pend;
    logic            brk_pend;
    logic            push;
    ev_t             push_dat;
    ev_t             head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
            filt   <= '0;
        end else begin
            clk_s1 <= ps2clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2data;
            dat_s2 <= dat_s1;
            filt   <= {filt[FILT-2:0], clk_s2};
        end
    end

    // Newest samples enter at bit 0; a clean fall is old-half high, new-half low.
    assign fall_edge = (&filt[FILT-1:HALF]) & ~(|filt[HALF-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            bcnt       <= '0;
            sh         <= '0;
            start_bit  <= 1'b0;
            to_cnt     <= '0;
            rx_vld     <= 1'b0;
            rx_byte    <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            rx_vld     <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            case (st)
                IDLE: begin
                    to_cnt <= '0;
                    if (fall_edge) begin
                        start_bit <= dat_s2;
                        bcnt      <= 4'd1;
                        st        <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_edge) begin
                        to_cnt <= '0;
                        if (bcnt == 4'd10) begin
                            st <= IDLE;
                            if (start_bit || !dat_s2) err_frame <= 1'b1;
                            else if (!(^sh))          err_parity <= 1'b1;
                            else begin
                                rx_vld  <= 1'b1;
                                rx_byte <= sh[7:0];
                            end
                        end else begin
                            sh   <= {dat_s2, sh[8:1]};
                            bcnt <= bcnt + 1'b1;
                        end
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        st        <= IDLE;
                        err_frame <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign push     = rx_vld && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
    assign push_dat = '{ext: ext_pend, brk: brk_pend, code: rx_byte};

    // Any error abandons a half-received prefix sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (err_parity || err_frame) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (rx_vld) begin
            if (rx_byte == 8'hE0)      ext_pend <= 1'b1;
            else if (rx_byte == 8'hF0) brk_pend <= 1'b1;
            else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

    ps2_fifo #(
        .WIDTH ($bits(ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push),
        .wr_dat (push_dat),
        .rd_vld (ev_valid),
        .rd_rdy (ev_ready),
        .rd_dat (head),
        .level  (level),
        .ovf    (overflow)
    );

    assign ev_code = head.code;
    assign ev_ext  = head.ext;
    assign ev_brk  = head.brk;
endmodule

// File: tb/tb_ps2_event_fifo.sv
// Directed bench for ps2_event_fifo: PS/2 frames driven on the pins, events and pulses logged at negedge.
module tb_ps2_event_fifo;
    localparam int FILT = 8;
    localparam int TO   = 200;
    localparam int DEP  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2clk;
    logic       ps2data;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;
    logic [2:0] level;

    int n_chk = 0;
    int n_bad = 0;

    int         cyc = 0;
    int         n_errp = 0, n_errf = 0, n_vld_hi = 0;
    int         errp_cyc = 0, errf_cyc = 0, vld_rise_cyc = 0;
    logic       vld_q = 1'b0;
    logic [9:0] pop_q[$];
    int         pop_cyc[$];
    int         last_fall_cyc = 0;

    ps2_event_fifo #(.FILT(FILT), .TIMEOUT(TO), .DEPTH(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_brk     (ev_brk),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (err_parity) begin n_errp++; errp_cyc = cyc; end
        if (err_frame)  begin n_errf++; errf_cyc = cyc; end
        if (ev_valid) n_vld_hi++;
        if (ev_valid && !vld_q) vld_rise_cyc = cyc;
        vld_q = ev_valid;
        if (ev_valid && ev_ready) begin
            pop_q.push_back({ev_ext, ev_brk, ev_code});
            pop_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each bit: data set up, clock low 10 clks, high 5 more clks.
    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2data = f[i];
            idle(5);
            ps2clk = 1'b0;
            last_fall_cyc = cyc;
            idle(10);
            ps2clk = 1'b1;
            idle(5);
        end
        ps2data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic p);
        send_bits(mk_frame(b, p), 11);
        idle(10);
    endtask

    int ep, ef, q0, h0;

    initial begin
        reset = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; ev_ready = 1'b0;
        idle(3);
        check("rst_valid", ev_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_code", ev_code, 0);
        reset = 1'b0;
        idle(20);
        check("idle_errs", {err_parity, err_frame}, 0);

        // Make 'A' with consumer ready.
        ev_ready = 1'b1;
        ep = n_errp; ef = n_errf; q0 = pop_q.size(); h0 = n_vld_hi;
        send(8'h1C, 1'b0);
        check("a_count", pop_q.size(), q0 + 1);
        if (pop_q.size() > q0) check("a_event", pop_q[q0], 10'h01C);
        check("a_lat", vld_rise_cyc - last_fall_cyc, 8);
        check("a_vld_width", n_vld_hi - h0, 1);
        check("a_errs", (n_errp - ep) + (n_errf - ef), 0);

        // Extended make, then extended break.
        q0 = pop_q.size();
        send(8'hE0, 1'b0); send(8'h74, 1'b1);
        send(8'hE0, 1'b0); send(8'hF0, 1'b1); send(8'h74, 1'b1);
        check("ext_count", pop_q.size(), q0 + 2);
        if (pop_q.size() > q0 + 1) begin
            check("ext_make", pop_q[q0], 10'h274);
            check("ext_brk", pop_q[q0+1], 10'h374);
        end

        // F0 pending, then a parity error must clear it.
        ep = n_errp; ef = n_errf; q0 = pop_q.size();
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        check("par_pulse", n_errp - ep, 1);
        check("par_lat", errp_cyc - last_fall_cyc, 7);
        check("par_level", level, 0);
        check("par_nopush", pop_q.size(), q0);
        send(8'h1C, 1'b0);
        check("par_after_cnt", pop_q.size(), q0 + 1);
        if (pop_q.size() > q0) check("par_after_ev", pop_q[q0], 10'h01C);
        check("par_noframe", n_errf - ef, 0);

        // Fill past DEPTH with consumer stalled.
        ev_ready = 1'b0;
        q0 = pop_q.size();
        send(8'h16, 1'b0); send(8'h1E, 1'b1); send(8'h26, 1'b0);
        send(8'h25, 1'b0); send(8'h2E, 1'b1);
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", ev_code, 8'h16);
        ev_ready = 1'b1;
        idle(10);
        check("ovf_drain_cnt", pop_q.size(), q0 + 4);
        if (pop_q.size() >= q0 + 4) begin
            check("ovf_ev0", pop_q[q0],   10'h016);
            check("ovf_ev1", pop_q[q0+1], 10'h01E);
            check("ovf_ev2", pop_q[q0+2], 10'h026);
            check("ovf_ev3", pop_q[q0+3], 10'h025);
            check("ovf_rate", pop_cyc[q0+3] - pop_cyc[q0], 3);
        end
        check("ovf_empty", level, 0);

        // Truncated frame: start + 3 data bits, then ps2clk stops.
        ep = n_errp; ef = n_errf;
        send_bits(mk_frame(8'h16, 1'b0), 4);
        idle(TO + 40);
        check("to_pulse", n_errf - ef, 1);
        begin
            int d;
            d = errf_cyc - last_fall_cyc;
            check("to_lat", (d >= TO + 6 && d <= TO + 8) ? TO + 7 : d, TO + 7);
        end
        check("to_nopar", n_errp - ep, 0);
        q0 = pop_q.size();
        send(8'h16, 1'b0);
        check("to_after_cnt", pop_q.size(), q0 + 1);
        if (pop_q.size() > q0) check("to_after_ev", pop_q[q0], 10'h016);

        // Reset in the middle of a frame with two events queued.
        ev_ready = 1'b0;
        send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        check("rm_level2", level, 2);
        ep = n_errp; ef = n_errf;
        send_bits(mk_frame(8'h1C, 1'b0), 4);
        reset = 1'b1;
        #1;
        check("rm_async_level", level, 0);
        idle(2);
        reset = 1'b0;
        idle(20);
        check("rm_level", level, 0);
        check("rm_valid", ev_valid, 0);
        check("rm_ovf", overflow, 0);
        check("rm_errs", (n_errp - ep) + (n_errf - ef), 0);
        ev_ready = 1'b1;
        q0 = pop_q.size();
        send(8'h1C, 1'b0);
        check("rm_after_cnt", pop_q.size(), q0 + 1);
        if (pop_q.size() > q0) check("rm_after_ev", pop_q[q0], 10'h01C);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
